// File: rtl/decode_issue_scoreboard_pkg.sv
// Shared constants for the decode issue scoreboard.
package decode_pkg;
   localparam int unsigned NUM_REGS = 16;
   localparam logic [3:0]  REG_PC   = 4'd15;
   localparam int unsigned CNT_W    = 2;
   localparam int unsigned MAX_INFL = 4;
   localparam int unsigned INFL_W   = 3;
   localparam int unsigned ADDR_W   = 4;
endpackage

// File: rtl/decode_issue_scoreboard_if.sv
// Decode/writeback bus between the issue stage (master) and the scoreboard (slave).
// Carries the decode request, writeback report, flush, and scoreboard status.
interface decode_issue_scoreboard_if;
   import decode_pkg::*;

   logic                id_valid;
   logic                id_ready;
   logic [ADDR_W-1:0]   id_ra1;
   logic [ADDR_W-1:0]   id_ra2;
   logic                id_use_ra1;
   logic                id_use_ra2;
   logic [ADDR_W-1:0]   id_rd;
   logic                id_we;
   logic                wb_valid;
   logic [ADDR_W-1:0]   wb_rd;
   logic                flush;
   logic                we3_out;
   logic                stall;
   logic [NUM_REGS-1:0] pending_mask;
   logic [INFL_W-1:0]   infl_cnt;

   modport master (
      output id_valid, id_ra1, id_ra2, id_use_ra1, id_use_ra2, id_rd, id_we,
             wb_valid, wb_rd, flush,
      input  id_ready, we3_out, stall, pending_mask, infl_cnt
   );

   modport slave (
      input  id_valid, id_ra1, id_ra2, id_use_ra1, id_use_ra2, id_rd, id_we,
             wb_valid, wb_rd, flush,
      output id_ready, we3_out, stall, pending_mask, infl_cnt
   );
endinterface

// File: rtl/decode_issue_scoreboard_counter.sv
// Per-register pending-write counter.
// Ports: clk, reset_n (sync, active low), inc, dec, clr -> count, nonzero.
// Callers guarantee inc never overflows and dec never underflows.
module scoreboard_counter #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             nonzero
);
   logic [CNT_W-1:0] count_q;

   // Simultaneous inc and dec cancel out.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && !dec) begin
         count_q <= count_q + CNT_W'(1);
      end else if (dec && !inc) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign count   = count_q;
   assign nonzero = (count_q != '0);
endmodule

// File: rtl/decode_issue_scoreboard.sv
// Issue scoreboard in front of the Decode register bank.
// Tracks in-flight writes to R0-R14, stalls Decode on RAW hazards or capacity,
// and gates the bank write enable to writebacks that match a tracked write.
// Ports: clk, reset_n (sync, active low), bus (slave modport): id_* request,
// wb_* writeback, flush, and id_ready/stall/we3_out (combinational),
// pending_mask/infl_cnt (registered state).
module decode_issue_scoreboard
   import decode_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset_n,
   decode_issue_scoreboard_if.slave   bus
);
   logic [CNT_W-1:0]    cnt [NUM_REGS];
   logic [NUM_REGS-1:0] pend;
   logic [NUM_REGS-2:0] inc_v;
   logic [NUM_REGS-2:0] dec_v;
   logic [INFL_W-1:0]   infl_q;
   logic                hazard;
   logic                full;
   logic                stall;
   logic                issue_wr;
   logic                accept;

   // R15 is never tracked: its slot reads as an empty counter.
   assign cnt[NUM_REGS-1]  = '0;
   assign pend[NUM_REGS-1] = 1'b0;

   // Hazard/capacity decode on pre-edge state; writebacks do not bypass.
   always_comb begin
      hazard   = 1'b0;
      full     = 1'b0;
      stall    = 1'b0;
      issue_wr = 1'b0;
      accept   = 1'b0;
      inc_v    = '0;
      dec_v    = '0;

      hazard = bus.id_valid &&
               ((bus.id_use_ra1 && pend[bus.id_ra1]) ||
                (bus.id_use_ra2 && pend[bus.id_ra2]));
      full   = bus.id_valid && bus.id_we && (bus.id_rd != REG_PC) &&
               ((infl_q == INFL_W'(MAX_INFL)) || (cnt[bus.id_rd] == '1));
      stall  = hazard || full;

      issue_wr = bus.id_valid && !stall && bus.id_we &&
                 (bus.id_rd != REG_PC) && !bus.flush;
      accept   = bus.wb_valid && pend[bus.wb_rd] && !bus.flush;

      for (int i = 0; i < NUM_REGS - 1; i++) begin
         inc_v[i] = issue_wr && (bus.id_rd == ADDR_W'(i));
         dec_v[i] = accept   && (bus.wb_rd == ADDR_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_cnt
      scoreboard_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk     (clk),
         .reset_n (reset_n),
         .inc     (inc_v[g]),
         .dec     (dec_v[g]),
         .clr     (bus.flush),
         .count   (cnt[g]),
         .nonzero (pend[g])
      );
   end

   // Total in-flight writers; always equals the sum of the per-register counters.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         infl_q <= '0;
      end else if (bus.flush) begin
         infl_q <= '0;
      end else if (issue_wr && !accept) begin
         infl_q <= infl_q + INFL_W'(1);
      end else if (accept && !issue_wr) begin
         infl_q <= infl_q - INFL_W'(1);
      end
   end

   assign bus.stall        = stall;
   assign bus.id_ready     = !stall;
   assign bus.we3_out      = accept;
   assign bus.pending_mask = pend;
   assign bus.infl_cnt     = infl_q;
endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// Self-checking bench for decode_issue_scoreboard: directed scenarios followed by
// random traffic, all compared against a per-register count model.
module tb_decode_issue_scoreboard;
   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   int   m_cnt [16];

   decode_issue_scoreboard_if bif ();

   decode_issue_scoreboard dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] ra1, input logic u1,
                        input logic [3:0] ra2, input logic u2,
                        input logic [3:0] rd, input logic we,
                        input logic wv, input logic [3:0] wrd, input logic fl);
      bif.id_valid   = v;
      bif.id_ra1     = ra1;
      bif.id_use_ra1 = u1;
      bif.id_ra2     = ra2;
      bif.id_use_ra2 = u2;
      bif.id_rd      = rd;
      bif.id_we      = we;
      bif.wb_valid   = wv;
      bif.wb_rd      = wrd;
      bif.flush      = fl;
   endtask

   // Check outputs against the model for the driven inputs, then advance one clock.
   task automatic tick();
      int        total;
      logic      e_haz, e_full, e_stall, e_we3;
      logic [15:0] e_mask;
      #1;
      total = 0;
      e_mask = '0;
      for (int r = 0; r < 15; r++) begin
         total += m_cnt[r];
         e_mask[r] = (m_cnt[r] > 0);
      end
      e_haz  = bif.id_valid &&
               ((bif.id_use_ra1 && bif.id_ra1 != 4'd15 && m_cnt[bif.id_ra1] > 0) ||
                (bif.id_use_ra2 && bif.id_ra2 != 4'd15 && m_cnt[bif.id_ra2] > 0));
      e_full = bif.id_valid && bif.id_we && bif.id_rd != 4'd15 &&
               (total == 4 || m_cnt[bif.id_rd] == 3);
      e_stall = e_haz || e_full;
      e_we3  = bif.wb_valid && bif.wb_rd != 4'd15 && m_cnt[bif.wb_rd] > 0 && !bif.flush;
      chk("stall",        32'(bif.stall),        32'(e_stall));
      chk("id_ready",     32'(bif.id_ready),     32'(!e_stall));
      chk("we3_out",      32'(bif.we3_out),      32'(e_we3));
      chk("pending_mask", 32'(bif.pending_mask), 32'(e_mask));
      chk("infl_cnt",     32'(bif.infl_cnt),     32'(total));
      @(posedge clk);
      if (!reset_n || bif.flush) begin
         for (int r = 0; r < 16; r++) m_cnt[r] = 0;
      end else begin
         if (bif.id_valid && !e_stall && bif.id_we && bif.id_rd != 4'd15)
            m_cnt[bif.id_rd]++;
         if (e_we3)
            m_cnt[bif.wb_rd]--;
      end
      @(negedge clk);
   endtask

   function automatic logic [3:0] pick();
      if ($urandom_range(0, 7) == 0) return 4'd15;
      if ($urandom_range(0, 5) == 0) return 4'($urandom_range(0, 14));
      return 4'($urandom_range(0, 3));
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      for (int r = 0; r < 16; r++) m_cnt[r] = 0;
      reset_n = 1'b0;
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      @(negedge clk);

      // Reset held two cycles with an instruction presented.
      tick();
      tick();
      reset_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_mask",  32'(bif.pending_mask), 32'h0);
      chk("rst_infl",  32'(bif.infl_cnt),     32'h0);
      chk("rst_ready", 32'(bif.id_ready),     32'h1);
      @(negedge clk);

      // RAW on R3: stall through the writeback cycle, clear the cycle after.
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
      drive(1, 3, 1, 0, 0, 8, 0, 0, 0, 0); tick(); tick();
      chk("raw_stall", 32'(bif.stall), 32'h1);
      drive(1, 3, 1, 0, 0, 8, 0, 1, 3, 0); tick();
      drive(1, 3, 1, 0, 0, 8, 0, 0, 0, 0);
      #1 chk("raw_release", 32'(bif.stall), 32'h0);
      @(negedge clk);
      tick();

      // Capacity: four writers fill the window, fifth stalls until a wb lands.
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
      #1 chk("cap_infl", 32'(bif.infl_cnt), 32'd4);
      @(negedge clk);
      tick();
      drive(1, 0, 0, 0, 0, 6, 1, 1, 1, 0); tick();
      drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0); tick();
      for (int r = 2; r <= 6; r++) begin
         if (r == 3) continue;
         drive(0, 0, 0, 0, 0, 0, 0, 1, 4'(r), 0); tick();
      end

      // Same register twice: mask bit stays until the last wb.
      drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); tick(); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); tick();
      #1 chk("same_reg_mask", 32'(bif.pending_mask[7]), 32'h1);
      tick();
      #1 chk("same_reg_clear", 32'(bif.pending_mask[7]), 32'h0);

      // Simultaneous issue and wb on R2.
      drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 2, 1, 1, 2, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("simul_infl", 32'(bif.infl_cnt), 32'd1);
      @(negedge clk);

      // Flush with a matching wb pending; R15 reads/writes never interact.
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
      drive(1, 15, 1, 15, 1, 9, 1, 1, 3, 1); tick();
      drive(1, 15, 1, 15, 1, 15, 1, 1, 15, 0); tick();
      #1 chk("flush_mask", 32'(bif.pending_mask), 32'h0);
      @(negedge clk);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         reset_n = ($urandom_range(0, 150) != 0);
         drive(1'($urandom_range(0, 1)), pick(), 1'($urandom_range(0, 1)),
               pick(), 1'($urandom_range(0, 1)), pick(), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 1)), pick(), ($urandom_range(0, 40) == 0));
         tick();
      end
      reset_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
